// File: rtl/usb_rst_sequencer.sv
// Sequences the external USB host controller reset: minimum low pulse, settle window,
// then a ready flag. A small Avalon-MM slave reports status, reset count and timer.
module usb_rst_sequencer #(
    parameter int unsigned PULSE_CYCLES  = 500,
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rst_req,
    output logic        usb_rst_n,
    output logic        usb_ready,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     timer;
    logic [CNT_W-1:0]     timer_nxt;
    logic [COUNT_W-1:0]   rst_count;
    logic [COUNT_W-1:0]   rst_count_nxt;
    logic                 count_inc;
    logic                 count_clr;
    logic                 wdata_unused;

    // Any write to RST_COUNT clears it; the data itself carries no meaning.
    assign count_clr    = chipselect && !write_n && (address == 2'd1);
    assign wdata_unused = ^writedata;

    // Next-state, timer and reset-counter logic.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        rst_count_nxt = rst_count;
        count_inc     = 1'b0;

        case (state)
            ST_ASSERT: begin
                if ((timer == PULSE_LAST) && !rst_req) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = '0;
                end else if (timer != PULSE_LAST) begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // A new request wins over the settle window finishing.
                if (rst_req) begin
                    state_nxt = ST_ASSERT;
                    timer_nxt = '0;
                    count_inc = 1'b1;
                end else if (timer == SETTLE_LAST) begin
                    state_nxt = ST_READY;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (rst_req) begin
                    state_nxt = ST_ASSERT;
                    timer_nxt = '0;
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                timer_nxt = '0;
            end
        endcase

        if (count_clr) begin
            rst_count_nxt = count_inc ? COUNT_W'(1) : '0;
        end else if (count_inc && (rst_count != {COUNT_W{1'b1}})) begin
            rst_count_nxt = rst_count + COUNT_W'(1);
        end
    end

    // Outputs are registered from the next state so the pin never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ASSERT;
            timer     <= '0;
            rst_count <= '0;
            usb_rst_n <= 1'b0;
            usb_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            rst_count <= rst_count_nxt;
            usb_rst_n <= (state_nxt != ST_ASSERT);
            usb_ready <= (state_nxt == ST_READY);
        end
    end

    // Zero-wait read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = DATA_W'({state, usb_ready});
            2'd1:    readdata = DATA_W'(rst_count);
            2'd2:    readdata = DATA_W'(timer);
            default: readdata = '0;
        endcase
    end

endmodule
